// File: rtl/tron_input_scheduler.sv
// Tron game controller: keyboard events drive the game FSM and per-player heading queues.
// Optional QUEUE_DEDUP_EN: drop a press that repeats the queue tail (or current heading).
module tron_input_scheduler #(
    parameter int unsigned TICK_DIV = 2500000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    input  logic         crash,
    output logic [1:0]   game_state,
    output logic         tick,
    output logic [1:0]   p1_dir,
    output logic [1:0]   p2_dir,
    output logic [1:0]   q_ovf
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned PW = $clog2(QDEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;

    logic       press;
    logic       key_start;
    logic       key_pause;
    logic [1:0] dir_req;
    logic [1:0] dir_code;

    assign press = key_valid & key_down[last_change];

    always_comb begin
        key_start = 1'b0;
        key_pause = 1'b0;
        dir_req   = 2'b00;
        dir_code  = 2'b00;
        if (press) begin
            case (last_change)
                9'h01D: begin dir_req = 2'b01; dir_code = 2'b00; end
                9'h023: begin dir_req = 2'b01; dir_code = 2'b01; end
                9'h01B: begin dir_req = 2'b01; dir_code = 2'b10; end
                9'h01C: begin dir_req = 2'b01; dir_code = 2'b11; end
                9'h175: begin dir_req = 2'b10; dir_code = 2'b00; end
                9'h174: begin dir_req = 2'b10; dir_code = 2'b01; end
                9'h172: begin dir_req = 2'b10; dir_code = 2'b10; end
                9'h16B: begin dir_req = 2'b10; dir_code = 2'b11; end
                9'h05A: key_start = 1'b1;
                9'h029: key_pause = 1'b1;
                default: ;
            endcase
        end
    end

    logic in_run;
    logic at_wrap;
    logic start_game;
    logic end_game;
    logic step;

    assign in_run     = (state_q == StRun);
    assign at_wrap    = (cnt_q == CW'(TICK_DIV - 1));
    assign tick       = in_run & at_wrap;
    assign start_game = (state_q == StIdle) & key_start;
    assign end_game   = crash & (state_q != StIdle);
    // A crash on a tick cycle ends the game before any heading update.
    assign step       = tick & ~crash;
    assign game_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (key_start) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    cnt_q <= at_wrap ? '0 : cnt_q + 1'b1;
                    if (crash) begin
                        state_q <= StIdle;
                    end else if (key_pause) begin
                        state_q <= StPause;
                    end
                end
                StPause: begin
                    if (crash) begin
                        state_q <= StIdle;
                    end else if (key_pause) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [1:0] dir_all [2];
    logic [1:0] ovf_all;

    for (genvar p = 0; p < 2; p++) begin : g_player
        localparam logic [1:0] DirInit = (p == 0) ? 2'b01 : 2'b11;
        localparam logic [PW:0] QFull  = (PW + 1)'(QDEPTH);

        logic [1:0]    mem_q [QDEPTH];
        logic [PW-1:0] rd_q;
        logic [PW-1:0] wr_q;
        logic [PW:0]   occ_q;
        logic [1:0]    dir_q;
        logic          ovf_q;

        logic [1:0] head;
        logic       full;
        logic       flush;
        logic       pop;
        logic       push_req;
        logic       dup;
        logic       push;

        assign head     = mem_q[rd_q];
        assign full     = (occ_q == QFull);
        assign flush    = start_game | end_game;
        assign pop      = step & (occ_q != '0);
        assign push_req = in_run & ~crash & dir_req[p];
`ifdef QUEUE_DEDUP_EN
        logic [1:0] tail;
        assign tail = mem_q[wr_q - 1'b1];
        assign dup  = (dir_code == ((occ_q != '0) ? tail : dir_q));
`else
        assign dup  = 1'b0;
`endif
        // A pop in the same cycle frees the slot a full-queue push needs.
        assign push = push_req & ~dup & (~full | pop);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q  <= '0;
                wr_q  <= '0;
                occ_q <= '0;
                dir_q <= DirInit;
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= push_req & ~dup & full & ~pop;
                if (flush) begin
                    rd_q  <= '0;
                    wr_q  <= '0;
                    occ_q <= '0;
                    if (start_game) begin
                        dir_q <= DirInit;
                    end
                end else begin
                    if (push) begin
                        wr_q <= wr_q + 1'b1;
                    end
                    if (pop) begin
                        rd_q <= rd_q + 1'b1;
                        if (head != (dir_q ^ 2'b10)) begin
                            dir_q <= head;
                        end
                    end
                    case ({push, pop})
                        2'b10:   occ_q <= occ_q + 1'b1;
                        2'b01:   occ_q <= occ_q - 1'b1;
                        default: ;
                    endcase
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_q] <= dir_code;
            end
        end

        assign dir_all[p] = dir_q;
        assign ovf_all[p] = ovf_q;
    end

    assign p1_dir = dir_all[0];
    assign p2_dir = dir_all[1];
    assign q_ovf  = ovf_all;

endmodule

// File: tb/tb_tron_input_scheduler.sv
// Scoreboard bench for tron_input_scheduler: a queue-based game model predicts every cycle's outputs.
module tb_tron_input_scheduler;

    localparam int TD = 4;
    localparam int QD = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [8:0]   last_change = '0;
    logic [511:0] key_down = '0;
    logic         crash = 1'b0;
    logic [1:0]   game_state;
    logic         tick;
    logic [1:0]   p1_dir;
    logic [1:0]   p2_dir;
    logic [1:0]   q_ovf;

    tron_input_scheduler #(
        .TICK_DIV(TD),
        .QDEPTH  (QD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .last_change(last_change),
        .key_down   (key_down),
        .crash      (crash),
        .game_state (game_state),
        .tick       (tick),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .q_ovf      (q_ovf)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] K_W = 9'h01D, K_D = 9'h023, K_S = 9'h01B, K_A = 9'h01C;
    localparam logic [8:0] K_UP = 9'h175, K_RT = 9'h174, K_DN = 9'h172, K_LT = 9'h16B;
    localparam logic [8:0] K_ENTER = 9'h05A, K_SPACE = 9'h029;

    typedef struct packed {
        logic [1:0] gs;
        logic       tk;
        logic [1:0] d1;
        logic [1:0] d2;
        logic [1:0] ov;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: game phase 0 idle / 1 run / 2 pause, a tick phase count, and plain command lists.
    int         m_state;
    int         m_cnt;
    logic [1:0] m_dir [2];
    logic [1:0] m_ovf;
    logic [1:0] mel [2][QD+1];
    int         msz [2];
    logic [8:0] keys [10];

    function automatic exp_t model_out();
        exp_t e;
        e.gs = 2'(m_state);
        e.tk = (m_state == 1) && (m_cnt == TD - 1);
        e.d1 = m_dir[0];
        e.d2 = m_dir[1];
        e.ov = m_ovf;
        return e;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_cnt    = 0;
        m_dir[0] = 2'b01;
        m_dir[1] = 2'b11;
        m_ovf    = 2'b00;
        msz[0]   = 0;
        msz[1]   = 0;
    endtask

    task automatic model_step(input logic kv, input logic [8:0] code, input logic dn,
                              input logic cr);
        logic       pr;
        int         dp;
        logic [1:0] dc;
        logic       dup;
        logic [1:0] novf;
        logic [1:0] h;
        pr   = kv && dn;
        dp   = -1;
        dc   = 2'b00;
        dup  = 1'b0;
        novf = 2'b00;
        if (pr) begin
            if (code == K_W) begin dp = 0; dc = 2'd0; end
            if (code == K_D) begin dp = 0; dc = 2'd1; end
            if (code == K_S) begin dp = 0; dc = 2'd2; end
            if (code == K_A) begin dp = 0; dc = 2'd3; end
            if (code == K_UP) begin dp = 1; dc = 2'd0; end
            if (code == K_RT) begin dp = 1; dc = 2'd1; end
            if (code == K_DN) begin dp = 1; dc = 2'd2; end
            if (code == K_LT) begin dp = 1; dc = 2'd3; end
        end
        if (m_state == 0) begin
            if (pr && code == K_ENTER) begin
                m_state  = 1;
                m_cnt    = 0;
                m_dir[0] = 2'b01;
                m_dir[1] = 2'b11;
                msz[0]   = 0;
                msz[1]   = 0;
            end
        end else if (cr) begin
            m_state = 0;
            msz[0]  = 0;
            msz[1]  = 0;
        end else if (m_state == 2) begin
            if (pr && code == K_SPACE) m_state = 1;
        end else begin
`ifdef QUEUE_DEDUP_EN
            if (dp >= 0) dup = (msz[dp] > 0) ? (mel[dp][msz[dp]-1] == dc) : (m_dir[dp] == dc);
`endif
            if (m_cnt == TD - 1) begin
                for (int p = 0; p < 2; p++) begin
                    if (msz[p] > 0) begin
                        h = mel[p][0];
                        for (int i = 0; i < QD; i++) mel[p][i] = mel[p][i+1];
                        msz[p]--;
                        if (h != (m_dir[p] ^ 2'b10)) m_dir[p] = h;
                    end
                end
            end
            if (dp >= 0 && !dup) begin
                if (msz[dp] == QD) novf[dp] = 1'b1;
                else begin
                    mel[dp][msz[dp]] = dc;
                    msz[dp]++;
                end
            end
            m_cnt = (m_cnt + 1) % TD;
            if (pr && code == K_SPACE) m_state = 2;
        end
        m_ovf = novf;
    endtask

    // Called at posedge+1: records this cycle's expected outputs, then drives its inputs.
    task automatic cyc(input logic kv, input logic [8:0] code, input logic dn, input logic cr);
        sbq.push_back(model_out());
        for (int i = 0; i < 16; i++) key_down[i*32 +: 32] = $urandom();
        key_down[code] = dn;
        key_valid   = kv;
        last_change = code;
        crash       = cr;
        if (!rst_n) model_reset();
        else model_step(kv, code, dn, cr);
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [8:0] code);
        cyc(1'b1, code, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic reset_now();
        exp_t e;
        exp_t a;
        rst_n = 1'b0;
        model_reset();
        #1;
        e = model_out();
        a = {game_state, tick, p1_dir, p2_dir, q_ovf};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL async_reset got %b want %b", a, e);
        end
        cyc(1'b0, 9'h000, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {game_state, tick, p1_dir, p2_dir, q_ovf};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_out t=%0t got gs=%b tick=%b p1=%b p2=%b ovf=%b want gs=%b tick=%b p1=%b p2=%b ovf=%b",
                         $time, a.gs, a.tk, a.d1, a.d2, a.ov, e.gs, e.tk, e.d1, e.d2, e.ov);
            end
        end
    end

    initial begin
        int r;
        logic [8:0] code;
        keys = '{K_W, K_D, K_S, K_A, K_UP, K_RT, K_DN, K_LT, K_ENTER, K_SPACE};
        model_reset();
        @(posedge clk);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        // Break of Enter is ignored, then start and watch ticks.
        cyc(1'b1, K_ENTER, 1'b0, 1'b0);
        press(K_ENTER);
        idle(9);
        press(K_S);
        press(K_A);
        idle(10);
        press(K_D);
        idle(6);
        press(K_A);
        idle(6);
        // Sustained P2 burst overflows the queue and exercises push-with-pop on full.
        for (int i = 0; i < 12; i++) press((i % 2 == 0) ? K_UP : K_LT);
        idle(20);
        idle(1);
        press(K_SPACE);
        idle(3);
        press(K_W);
        idle(2);
        press(K_SPACE);
        idle(6);
        press(K_DN);
        press(K_RT);
        cyc(1'b1, K_SPACE, 1'b1, 1'b1);
        idle(3);
        press(K_ENTER);
        press(K_S);
        press(K_UP);
        idle(1);
        reset_now();
        idle(3);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 15);
            if (r < 10) code = keys[r];
            else code = 9'($urandom_range(0, 511));
            if (m_state == 0 && $urandom_range(0, 3) == 0) code = K_ENTER;
            if (code == K_SPACE && $urandom_range(0, 2) != 0) code = K_W;
            cyc(1'($urandom_range(0, 1)), code, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 99) == 0));
            if (n == 2500 && m_state != 0) reset_now();
        end
        idle(2);
        reset_now();
        idle(2);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
